// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, operand read, execute, writeback.
// RAM accesses use a req/ready handshake guarded by a wait-state timeout.
module instr_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       dec_mode,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             opr_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             gpr_we,
    output logic [1:0]       b_sel,
    output logic [1:0]       out_sel,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, OPER, EXEC, WB, HALT, ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg;
    logic [1:0]        b_sel_reg, out_sel_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              wait_expired;
    logic              wb_done;

    // A ready arriving on the last allowed wait cycle still completes the access.
    assign wait_expired = (wait_reg == WAIT_W'(TIMEOUT - 1)) && !mem_ready;
    assign wb_done      = (state_reg == WB) && ((out_sel_reg != 2'b10) || mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            wait_reg    <= '0;
            b_sel_reg   <= 2'b00;
            out_sel_reg <= 2'b00;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                wait_reg <= '0;
            else if (mem_req && !mem_ready)
                wait_reg <= wait_reg + WAIT_W'(1);
            if (state_reg == DECODE) begin
                b_sel_reg   <= dec_mode;
                out_sel_reg <= {dec_store, dec_branch};
            end
            if (wb_done)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (run) state_next = FETCH;
            FETCH:  begin
                if (mem_ready)         state_next = DECODE;
                else if (wait_expired) state_next = ERROR;
            end
            DECODE: begin
                if (dec_halt)               state_next = HALT;
                else if (dec_mode == 2'b01) state_next = OPER;
                else                        state_next = EXEC;
            end
            OPER:   begin
                if (mem_ready)         state_next = EXEC;
                else if (wait_expired) state_next = ERROR;
            end
            EXEC:   state_next = WB;
            WB:     begin
                if (wb_done)           state_next = run ? FETCH : IDLE;
                else if (wait_expired) state_next = ERROR;
            end
            HALT:   state_next = HALT;
            ERROR:  state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        opr_load = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        gpr_we   = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            OPER: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                opr_load = mem_ready;
            end
            WB: begin
                // 00 and 11 both fall through to the GPR path, like the ALU output mux.
                case (out_sel_reg)
                    2'b01:   pc_load = 1'b1;
                    2'b10: begin
                        mem_req  = 1'b1;
                        mem_we   = 1'b1;
                        addr_sel = 1'b1;
                    end
                    default: gpr_we = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign busy        = (state_reg != IDLE) && (state_reg != HALT) && (state_reg != ERROR);
    assign halted      = (state_reg == HALT);
    assign timeout_err = (state_reg == ERROR);
    assign b_sel       = b_sel_reg;
    assign out_sel     = out_sel_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: cycle-vector table, timeout corner sequences and a
// randomized run against an instruction-plan reference model.
module tb_instr_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    // Strobe bundle bit order: req we addr ir opr pcinc pcload gpr busy halted err
    localparam logic [10:0] B_REQ  = 11'b100_0000_0000;
    localparam logic [10:0] B_WE   = 11'b010_0000_0000;
    localparam logic [10:0] B_ADDR = 11'b001_0000_0000;
    localparam logic [10:0] B_IR   = 11'b000_1000_0000;
    localparam logic [10:0] B_OPR  = 11'b000_0100_0000;
    localparam logic [10:0] B_PCI  = 11'b000_0010_0000;
    localparam logic [10:0] B_PCL  = 11'b000_0001_0000;
    localparam logic [10:0] B_GPR  = 11'b000_0000_1000;
    localparam logic [10:0] B_BUSY = 11'b000_0000_0100;
    localparam logic [10:0] B_HLT  = 11'b000_0000_0010;
    localparam logic [10:0] B_ERR  = 11'b000_0000_0001;

    localparam logic [10:0] E_IDLE       = 11'b0;
    localparam logic [10:0] E_BUSY       = B_BUSY;
    localparam logic [10:0] E_FETCH_RDY  = B_REQ | B_IR | B_PCI | B_BUSY;
    localparam logic [10:0] E_FETCH_WAIT = B_REQ | B_BUSY;
    localparam logic [10:0] E_OPER_WAIT  = B_REQ | B_ADDR | B_BUSY;
    localparam logic [10:0] E_OPER_RDY   = B_REQ | B_ADDR | B_OPR | B_BUSY;
    localparam logic [10:0] E_STORE      = B_REQ | B_WE | B_ADDR | B_BUSY;
    localparam logic [10:0] E_GPR        = B_GPR | B_BUSY;
    localparam logic [10:0] E_BR         = B_PCL | B_BUSY;
    localparam logic [10:0] E_HALT       = B_HLT;
    localparam logic [10:0] E_ERR        = B_ERR;

    logic             clk = 1'b0;
    logic             reset, run, dec_store, dec_branch, dec_halt, mem_ready;
    logic [1:0]       dec_mode;
    logic             mem_req, mem_we, addr_sel, ir_load, opr_load, pc_inc, pc_load, gpr_we;
    logic [1:0]       b_sel, out_sel;
    logic             busy, halted, timeout_err;
    logic [CNT_W-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .dec_mode(dec_mode),
        .dec_store(dec_store), .dec_branch(dec_branch), .dec_halt(dec_halt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .opr_load(opr_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .gpr_we(gpr_we), .b_sel(b_sel), .out_sel(out_sel), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rst, run, st, br, hlt, rdy;
        logic [1:0]  mode;
        logic [10:0] strb;
        logic [1:0]  bs, os;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input bit rst_i, input bit run_i, input logic [1:0] mode_i,
                       input bit st_i, input bit br_i, input bit hlt_i, input bit rdy_i,
                       input logic [10:0] strb_i, input logic [1:0] bs_i, input logic [1:0] os_i,
                       input int cnt_i);
        vec_t v;
        v.name = nm; v.rst = rst_i; v.run = run_i; v.mode = mode_i; v.st = st_i; v.br = br_i;
        v.hlt = hlt_i; v.rdy = rdy_i; v.strb = strb_i; v.bs = bs_i; v.os = os_i; v.cnt = cnt_i;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rst_i, input bit run_i, input logic [1:0] mode_i,
                         input bit st_i, input bit br_i, input bit hlt_i, input bit rdy_i);
        reset = rst_i; run = run_i; dec_mode = mode_i;
        dec_store = st_i; dec_branch = br_i; dec_halt = hlt_i; mem_ready = rdy_i;
    endtask

    task automatic check(input string name, input logic [10:0] e_strb, input logic [1:0] e_bs,
                         input logic [1:0] e_os, input logic [CNT_W-1:0] e_cnt);
        logic [10:0] a_strb;
        a_strb = {mem_req, mem_we, addr_sel, ir_load, opr_load, pc_inc, pc_load, gpr_we,
                  busy, halted, timeout_err};
        n_tests++;
        if (a_strb !== e_strb || b_sel !== e_bs || out_sel !== e_os || instr_count !== e_cnt) begin
            n_fail++;
            $display("FAIL %s: got strb=%b b_sel=%b out_sel=%b count=%0d, expected strb=%b b_sel=%b out_sel=%b count=%0d",
                     name, a_strb, b_sel, out_sel, instr_count, e_strb, e_bs, e_os, e_cnt);
        end
    endtask

    // Reference model: an instruction is a plan of steps consumed one per cycle;
    // memory steps are consumed only when RAM answers.
    localparam int P_FETCH = 0, P_DEC = 1, P_OPER = 2, P_EXEC = 3, P_WB = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;
    int               m_st;
    int               plan[$];
    int               m_wait;
    logic [1:0]       m_bs, m_os;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_reset();
        m_st = M_IDLE; plan.delete(); m_wait = 0; m_bs = 2'b00; m_os = 2'b00; m_cnt = '0;
    endtask

    function automatic logic [10:0] model_strb(input bit rdy);
        logic [10:0] s;
        s = '0;
        if (m_st == M_HALT) s = B_HLT;
        else if (m_st == M_ERR) s = B_ERR;
        else if (m_st == M_RUN) begin
            s = B_BUSY;
            if (plan[0] == P_FETCH) s |= B_REQ | (rdy ? (B_IR | B_PCI) : 11'b0);
            else if (plan[0] == P_OPER) s |= B_REQ | B_ADDR | (rdy ? B_OPR : 11'b0);
            else if (plan[0] == P_WB) begin
                if (m_os == 2'b01) s |= B_PCL;
                else if (m_os == 2'b10) s |= B_REQ | B_WE | B_ADDR;
                else s |= B_GPR;
            end
        end
        return s;
    endfunction

    task automatic model_step(input bit rst_i, input bit run_i, input logic [1:0] mode_i,
                              input bit st_i, input bit br_i, input bit hlt_i, input bit rdy_i);
        int  h;
        bit  is_mem;
        if (rst_i) begin
            model_reset();
            return;
        end
        if (m_st == M_IDLE) begin
            if (run_i) begin
                m_st = M_RUN; plan.push_back(P_FETCH); plan.push_back(P_DEC);
            end
            return;
        end
        if (m_st != M_RUN) return;
        h = plan[0];
        is_mem = (h == P_FETCH) || (h == P_OPER) || (h == P_WB && m_os == 2'b10);
        if (is_mem && !rdy_i) begin
            if (m_wait >= TIMEOUT - 1) begin
                m_st = M_ERR; plan.delete();
            end else m_wait++;
            return;
        end
        m_wait = 0;
        void'(plan.pop_front());
        if (h == P_DEC) begin
            m_bs = mode_i; m_os = {st_i, br_i};
            if (hlt_i) begin
                m_st = M_HALT; plan.delete();
            end else begin
                if (mode_i == 2'b01) plan.push_back(P_OPER);
                plan.push_back(P_EXEC); plan.push_back(P_WB);
            end
        end else if (h == P_WB) begin
            m_cnt = m_cnt + 1'b1;
            if (run_i) begin
                plan.push_back(P_FETCH); plan.push_back(P_DEC);
            end else m_st = M_IDLE;
        end
    endtask

    initial begin
        int stuck;
        bit r_rst, r_run, r_st, r_br, r_hlt, r_rdy;
        logic [1:0] r_mode;
        logic [CNT_W-1:0] prev_cnt;

        // T1: register mode, GPR writeback
        add("t1_idle",   0,1,2'b10,0,0,0,1, E_IDLE,      2'b00,2'b00,0);
        add("t1_fetch",  0,1,2'b10,0,0,0,1, E_FETCH_RDY, 2'b00,2'b00,0);
        add("t1_decode", 0,1,2'b10,0,0,0,1, E_BUSY,      2'b00,2'b00,0);
        add("t1_exec",   0,1,2'b10,0,0,0,1, E_BUSY,      2'b10,2'b00,0);
        add("t1_wb",     0,0,2'b10,0,0,0,1, E_GPR,       2'b10,2'b00,0);
        add("t1_done",   0,0,2'b10,0,0,0,1, E_IDLE,      2'b10,2'b00,1);
        // T2: direct mode, operand read waits 3 cycles
        add("t2_idle",   0,1,2'b01,0,0,0,1, E_IDLE,      2'b10,2'b00,1);
        add("t2_fetch",  0,1,2'b01,0,0,0,1, E_FETCH_RDY, 2'b10,2'b00,1);
        add("t2_decode", 0,1,2'b01,0,0,0,1, E_BUSY,      2'b10,2'b00,1);
        add("t2_oper_w1",0,1,2'b01,0,0,0,0, E_OPER_WAIT, 2'b01,2'b00,1);
        add("t2_oper_w2",0,1,2'b01,0,0,0,0, E_OPER_WAIT, 2'b01,2'b00,1);
        add("t2_oper_w3",0,1,2'b01,0,0,0,0, E_OPER_WAIT, 2'b01,2'b00,1);
        add("t2_oper_ok",0,1,2'b01,0,0,0,1, E_OPER_RDY,  2'b01,2'b00,1);
        add("t2_exec",   0,1,2'b01,0,0,0,1, E_BUSY,      2'b01,2'b00,1);
        add("t2_wb",     0,0,2'b01,0,0,0,1, E_GPR,       2'b01,2'b00,1);
        add("t2_done",   0,0,2'b01,0,0,0,1, E_IDLE,      2'b01,2'b00,2);
        // T3: store waits in WB, then back-to-back branch
        add("t3_idle",   0,1,2'b00,1,0,0,1, E_IDLE,      2'b01,2'b00,2);
        add("t3_fetch",  0,1,2'b00,1,0,0,1, E_FETCH_RDY, 2'b01,2'b00,2);
        add("t3_decode", 0,1,2'b00,1,0,0,1, E_BUSY,      2'b01,2'b00,2);
        add("t3_exec",   0,1,2'b00,1,0,0,1, E_BUSY,      2'b00,2'b10,2);
        add("t3_st_w1",  0,1,2'b00,1,0,0,0, E_STORE,     2'b00,2'b10,2);
        add("t3_st_w2",  0,1,2'b00,1,0,0,0, E_STORE,     2'b00,2'b10,2);
        add("t3_st_ok",  0,1,2'b00,1,0,0,1, E_STORE,     2'b00,2'b10,2);
        add("t3_fetch2", 0,1,2'b00,0,1,0,1, E_FETCH_RDY, 2'b00,2'b10,3);
        add("t3_decode2",0,1,2'b00,0,1,0,1, E_BUSY,      2'b00,2'b10,3);
        add("t3_exec2",  0,1,2'b00,0,1,0,1, E_BUSY,      2'b00,2'b01,3);
        add("t3_branch", 0,0,2'b00,0,1,0,1, E_BR,        2'b00,2'b01,3);
        add("t3_done",   0,0,2'b00,0,1,0,1, E_IDLE,      2'b00,2'b01,4);
        // T6: run dropped in EXEC still retires; store+branch writes GPR
        add("t6_idle",   0,1,2'b11,1,1,0,1, E_IDLE,      2'b00,2'b01,4);
        add("t6_fetch",  0,1,2'b11,1,1,0,1, E_FETCH_RDY, 2'b00,2'b01,4);
        add("t6_decode", 0,1,2'b11,1,1,0,1, E_BUSY,      2'b00,2'b01,4);
        add("t6_exec",   0,0,2'b11,1,1,0,1, E_BUSY,      2'b11,2'b11,4);
        add("t6_wb",     0,0,2'b11,1,1,0,1, E_GPR,       2'b11,2'b11,4);
        add("t6_done",   0,0,2'b11,1,1,0,1, E_IDLE,      2'b11,2'b11,5);
        add("t6_stay",   0,0,2'b11,1,1,0,1, E_IDLE,      2'b11,2'b11,5);
        // T5: halt wins over store; reset during operand read
        add("t5_idle",   0,1,2'b00,1,0,1,1, E_IDLE,      2'b11,2'b11,5);
        add("t5_fetch",  0,1,2'b00,1,0,1,1, E_FETCH_RDY, 2'b11,2'b11,5);
        add("t5_decode", 0,1,2'b00,1,0,1,1, E_BUSY,      2'b11,2'b11,5);
        add("t5_halt",   0,1,2'b00,1,0,1,1, E_HALT,      2'b00,2'b10,5);
        add("t5_halt2",  1,1,2'b00,1,0,1,1, E_HALT,      2'b00,2'b10,5);
        add("t5_rst_idle",0,1,2'b01,0,0,0,1,E_IDLE,      2'b00,2'b00,0);
        add("t5_fetch2", 0,1,2'b01,0,0,0,1, E_FETCH_RDY, 2'b00,2'b00,0);
        add("t5_decode2",0,1,2'b01,0,0,0,1, E_BUSY,      2'b00,2'b00,0);
        add("t5_oper",   1,1,2'b01,0,0,0,0, E_OPER_WAIT, 2'b01,2'b00,0);
        add("t5_aborted",0,0,2'b01,0,0,0,0, E_IDLE,      2'b00,2'b00,0);

        drive(1,0,2'b00,0,0,0,0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].run, vecs[i].mode, vecs[i].st, vecs[i].br,
                  vecs[i].hlt, vecs[i].rdy);
            #4;
            check(vecs[i].name, vecs[i].strb, vecs[i].bs, vecs[i].os, vecs[i].cnt);
            $display("[TB] vec %0d %s strb=%b count=%0d", i, vecs[i].name,
                     {mem_req, mem_we, addr_sel, ir_load, opr_load, pc_inc, pc_load, gpr_we,
                      busy, halted, timeout_err}, instr_count);
        end

        // T4: fetch never answered -> ERROR after TIMEOUT cycles, sticky until reset
        @(posedge clk); #1; drive(1,0,2'b10,0,0,0,0);
        @(posedge clk); #1; drive(0,1,2'b10,0,0,0,0); #4;
        check("t4_idle", E_IDLE, 2'b00, 2'b00, 0);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #5;
            check($sformatf("t4_wait%0d", k), E_FETCH_WAIT, 2'b00, 2'b00, 0);
        end
        @(posedge clk); #1; drive(0,1,2'b10,0,0,0,1); #4;
        check("t4_error", E_ERR, 2'b00, 2'b00, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #5;
            check($sformatf("t4_sticky%0d", k), E_ERR, 2'b00, 2'b00, 0);
        end
        $display("[TB] timeout sequence done err=%b", timeout_err);

        // Ready on the last allowed wait cycle wins over the timeout
        @(posedge clk); #1; drive(1,0,2'b10,0,0,0,0);
        @(posedge clk); #1; drive(0,1,2'b10,0,0,0,0); #4;
        check("edge_idle", E_IDLE, 2'b00, 2'b00, 0);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            @(posedge clk); #5;
            check($sformatf("edge_wait%0d", k), E_FETCH_WAIT, 2'b00, 2'b00, 0);
        end
        @(posedge clk); #1; drive(0,1,2'b10,0,0,0,1); #4;
        check("edge_ready", E_FETCH_RDY, 2'b00, 2'b00, 0);
        @(posedge clk); #5;
        check("edge_decode", E_BUSY, 2'b00, 2'b00, 0);
        $display("[TB] late-ready sequence done busy=%b", busy);

        // Randomized run against the reference model
        @(posedge clk); #1; drive(1,0,2'b00,0,0,0,0);
        @(posedge clk);
        model_reset();
        stuck = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            #1;
            r_rdy  = ((cyc % 600) >= 300 && (cyc % 600) < 320) ? 1'b0 : ($urandom_range(0, 9) < 6);
            r_run  = ($urandom_range(0, 19) != 0);
            r_hlt  = ($urandom_range(0, 49) == 0);
            r_mode = 2'($urandom_range(0, 3));
            r_st   = 1'($urandom_range(0, 1));
            r_br   = 1'($urandom_range(0, 1));
            stuck  = (m_st >= M_HALT) ? stuck + 1 : 0;
            r_rst  = (stuck > 3) || ($urandom_range(0, 299) == 0);
            drive(r_rst, r_run, r_mode, r_st, r_br, r_hlt, r_rdy);
            #4;
            check($sformatf("rnd%0d", cyc), model_strb(r_rdy), m_bs, m_os, m_cnt);
            prev_cnt = m_cnt;
            model_step(r_rst, r_run, r_mode, r_st, r_br, r_hlt, r_rdy);
            if (m_cnt != prev_cnt)
                $display("[TB] rnd cycle %0d retired instr, count=%0d", cyc, m_cnt);
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
